// File: rtl/spi_txn_arb.sv
// spi_txn_arb: round-robin arbiter sharing one SPI controller between requesters, one word per transaction
module spi_txn_arb #(
    parameter int NUM_REQ = 4,
    parameter int TO_MS   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_1k_fp,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*2-1:0]  req_slv,
    input  logic [NUM_REQ*2-1:0]  req_len,
    input  logic [NUM_REQ-1:0]    req_rd,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2:0]            rsp_id,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  spi_strt,
    output logic [1:0]            spi_slv_sel,
    output logic [1:0]            spi_wd_len,
    output logic [1:0]            spi_rd_len,
    output logic                  spi_rdata_en,
    output logic                  spi_wd_lst,
    output logic                  spi_rd_lst,
    output logic [31:0]           spi_rwdata,
    input  logic                  spi_done,
    input  logic [31:0]           spi_rdata,
    output logic                  busy
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;
    state_t             state_q, state_d;
    logic [IW-1:0]      last_q, last_d, gnt_q, gnt_d, pick, pick_hi, pick_all;
    logic [1:0]         slv_q, slv_d, len_q, len_d, sel_slv, sel_len;
    logic               rd_q, rd_d, err_q, err_d, sel_rd;
    logic [31:0]        wdata_q, wdata_d, rdata_q, rdata_d, sel_wdata;
    logic [7:0]         cnt_q, cnt_d;
    logic [NUM_REQ-1:0] hi_mask, masked;
    always_comb begin
        hi_mask = ~((NUM_REQ'(2) << last_q) - NUM_REQ'(1));
        masked = req_valid & hi_mask;
        pick_hi = '0;
        pick_all = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            pick_hi = masked[i] ? IW'(i) : pick_hi;
            pick_all = req_valid[i] ? IW'(i) : pick_all;
        end
        pick = |masked ? pick_hi : pick_all;
        sel_slv = '0;
        sel_len = '0;
        sel_rd = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == pick) begin
                sel_slv = req_slv[2*i +: 2];
                sel_len = req_len[2*i +: 2];
                sel_rd = req_rd[i];
                sel_wdata = req_wdata[32*i +: 32];
            end
        end
    end
    always_comb begin
        state_d = state_q;
        last_d = last_q;
        gnt_d = gnt_q;
        slv_d = slv_q;
        len_d = len_q;
        rd_d = rd_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d = err_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: if (|req_valid) begin
                gnt_d = pick;
                slv_d = sel_slv;
                len_d = sel_len;
                rd_d = sel_rd;
                wdata_d = sel_wdata;
                state_d = LAUNCH;
            end
            LAUNCH: begin
                cnt_d = '0;
                state_d = WAIT;
            end
            WAIT: if (spi_done) begin
                rdata_d = rd_q ? spi_rdata : '0;
                err_d = 1'b0;
                state_d = RESP;
            end else if (clk_1k_fp) begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q + 8'd1 == 8'(TO_MS)) begin
                    rdata_d = '0;
                    err_d = 1'b1;
                    state_d = RESP;
                end
            end
            default: if (rsp_ready) begin
                last_d = gnt_q;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q <= IW'(NUM_REQ - 1);
            gnt_q <= '0;
            slv_q <= '0;
            len_q <= '0;
            rd_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            gnt_q <= gnt_d;
            slv_q <= slv_d;
            len_q <= len_d;
            rd_q <= rd_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end
    assign req_ready = (rst_n && state_q == IDLE && |req_valid) ? NUM_REQ'(1) << pick : '0;
    assign rsp_valid = state_q == RESP;
    assign rsp_id = 3'(gnt_q);
    assign rsp_rdata = rdata_q;
    assign rsp_err = err_q;
    assign spi_strt = state_q == LAUNCH;
    assign spi_slv_sel = slv_q;
    assign spi_wd_len = len_q;
    assign spi_rd_len = len_q;
    assign spi_rdata_en = rd_q;
    assign spi_wd_lst = 1'b1;
    assign spi_rd_lst = 1'b1;
    assign spi_rwdata = wdata_q;
    assign busy = state_q != IDLE;
endmodule

// File: tb/tb_spi_txn_arb.sv
// tb_spi_txn_arb: directed self-checking bench for spi_txn_arb with a short timeout
module tb_spi_txn_arb;
    logic        clk = 1'b0, rst_n = 1'b0, clk_1k_fp = 1'b0;
    logic [3:0]  req_valid = '0, req_ready, req_rd;
    logic [7:0]  req_slv, req_len;
    logic [127:0] req_wdata;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err, spi_strt, spi_rdata_en, spi_wd_lst, spi_rd_lst, busy;
    logic [2:0]  rsp_id;
    logic [31:0] rsp_rdata, spi_rwdata, spi_rdata = '0, held;
    logic [1:0]  spi_slv_sel, spi_wd_len, spi_rd_len;
    logic        spi_done = 1'b0;
    logic [31:0] wd [4] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    int errors = 0, checks = 0;
    spi_txn_arb #(.NUM_REQ(4), .TO_MS(4)) dut (
        .clk(clk), .rst_n(rst_n), .clk_1k_fp(clk_1k_fp),
        .req_valid(req_valid), .req_ready(req_ready), .req_slv(req_slv), .req_len(req_len),
        .req_rd(req_rd), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .spi_strt(spi_strt), .spi_slv_sel(spi_slv_sel), .spi_wd_len(spi_wd_len), .spi_rd_len(spi_rd_len),
        .spi_rdata_en(spi_rdata_en), .spi_wd_lst(spi_wd_lst), .spi_rd_lst(spi_rd_lst), .spi_rwdata(spi_rwdata),
        .spi_done(spi_done), .spi_rdata(spi_rdata), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic txn(input int id, input bit drop, input int delay, input logic [31:0] rdat);
        #1;
        chk("ready", 32'(req_ready), 32'(4'b1 << id));
        tick();
        if (drop) req_valid[id] = 1'b0;
        chk("strt", 32'(spi_strt), 1);
        chk("rwdata", spi_rwdata, wd[id]);
        chk("rdata_en", 32'(spi_rdata_en), 32'(req_rd[id]));
        tick();
        chk("strt_pulse", 32'(spi_strt), 0);
        repeat (delay) tick();
        spi_done = 1'b1;
        spi_rdata = rdat;
        tick();
        spi_done = 1'b0;
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_id", 32'(rsp_id), 32'(id));
        chk("rsp_rdata", rsp_rdata, req_rd[id] ? rdat : 32'h0);
        chk("rsp_err", 32'(rsp_err), 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_drop", 32'(rsp_valid), 0);
    endtask
    initial begin
        req_slv = {2'd1, 2'd0, 2'd3, 2'd2};
        req_len = {2'd0, 2'd1, 2'd2, 2'd3};
        req_rd = 4'b1011;
        req_wdata = {wd[3], wd[2], wd[1], wd[0]};
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_strt", 32'(spi_strt), 0);
        chk("rst_rwdata", spi_rwdata, 0);
        chk("rst_wd_lst", 32'(spi_wd_lst), 1);
        chk("rst_rd_lst", 32'(spi_rd_lst), 1);
        rst_n = 1'b1;
        tick();
        // single read from requester 0
        req_valid = 4'b0001;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        chk("t1_strt", 32'(spi_strt), 1);
        chk("t1_slv", 32'(spi_slv_sel), 2);
        chk("t1_wd_len", 32'(spi_wd_len), 3);
        chk("t1_rd_len", 32'(spi_rd_len), 3);
        chk("t1_rdata_en", 32'(spi_rdata_en), 1);
        chk("t1_busy", 32'(busy), 1);
        tick();
        chk("t1_strt_low", 32'(spi_strt), 0);
        chk("t1_slv_hold", 32'(spi_slv_sel), 2);
        spi_done = 1'b1;
        spi_rdata = 32'h1234_5678;
        tick();
        spi_done = 1'b0;
        chk("t1_rsp_valid", 32'(rsp_valid), 1);
        chk("t1_rsp_id", 32'(rsp_id), 0);
        chk("t1_rsp_rdata", rsp_rdata, 32'h1234_5678);
        chk("t1_rsp_err", 32'(rsp_err), 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t1_idle", 32'(busy), 0);
        // grant 1, then reset while waiting on the controller
        req_valid = 4'b0010;
        #1;
        chk("t5_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0000;
        tick();
        chk("t5_busy", 32'(busy), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_busy_rst", 32'(busy), 0);
        chk("t5_rsp_rst", 32'(rsp_valid), 0);
        chk("t5_rwdata_rst", spi_rwdata, 0);
        // round robin from reset priority
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) txn(k % 4, 1'b0, k, 32'hD000_0000 + 32'(k));
        req_valid = 4'b0000;
        // timeout on requester 2
        req_valid = 4'b0100;
        #1;
        chk("t3_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        chk("t3_strt", 32'(spi_strt), 1);
        tick();
        for (int k = 0; k < 3; k++) begin
            clk_1k_fp = 1'b1;
            tick();
            clk_1k_fp = 1'b0;
            tick();
            chk("t3_no_rsp", 32'(rsp_valid), 0);
        end
        clk_1k_fp = 1'b1;
        tick();
        clk_1k_fp = 1'b0;
        chk("t3_rsp_valid", 32'(rsp_valid), 1);
        chk("t3_rsp_err", 32'(rsp_err), 1);
        chk("t3_rsp_rdata", rsp_rdata, 0);
        chk("t3_rsp_id", 32'(rsp_id), 2);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        // backpressure on a response to requester 3
        req_valid = 4'b1011;
        #1;
        chk("t4_ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0011;
        chk("t4_rwdata", spi_rwdata, wd[3]);
        tick();
        spi_done = 1'b1;
        spi_rdata = 32'h5A5A_C3C3;
        tick();
        spi_done = 1'b0;
        held = rsp_rdata;
        chk("t4_rdata", held, 32'h5A5A_C3C3);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t4_hold_valid", 32'(rsp_valid), 1);
            chk("t4_hold_rdata", rsp_rdata, 32'h5A5A_C3C3);
            chk("t4_hold_id", 32'(rsp_id), 3);
            chk("t4_no_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        txn(0, 1'b1, 2, 32'h0BAD_F00D);
        // done collides with the terminal tick on requester 1
        #1;
        chk("t6_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0000;
        tick();
        for (int k = 0; k < 3; k++) begin
            clk_1k_fp = 1'b1;
            tick();
            clk_1k_fp = 1'b0;
            tick();
        end
        clk_1k_fp = 1'b1;
        spi_done = 1'b1;
        spi_rdata = 32'hCAFE_F00D;
        tick();
        clk_1k_fp = 1'b0;
        spi_done = 1'b0;
        chk("t6_rsp_valid", 32'(rsp_valid), 1);
        chk("t6_rsp_err", 32'(rsp_err), 0);
        chk("t6_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        // stray done while idle
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        tick();
        chk("stray_busy", 32'(busy), 0);
        chk("stray_rsp", 32'(rsp_valid), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
